// File: rtl/v1_filter_ctrl_pkg.sv
// Shared types and timing constants for the filter controller and its peak-hold helper.
package v1_param;

  // Width of the shaping-filter samples and threshold.
  localparam int SIZE_FILTER_DATA = 16;

  // Filter geometry terms that set how long the filter needs to settle after its reset.
  localparam int l_var1 = 4;
  localparam int k_var1 = 2;

  localparam int FLUSH_CYCLES  = 4;
  localparam int SETTLE_CYCLES = l_var1 + k_var1 + 6;

  // Counter wide enough for the longer of the two timed phases.
  localparam int CNT_W = $clog2((SETTLE_CYCLES > FLUSH_CYCLES) ? SETTLE_CYCLES : FLUSH_CYCLES) + 1;

  typedef logic signed [SIZE_FILTER_DATA-1:0] sample_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FLUSH,
    S_SETTLE,
    S_ARMED,
    S_PEAK,
    S_REPORT
  } state_t;

  // Rising threshold crossing: previous sample at or below, current sample strictly above.
  function automatic logic rising_cross(sample_t prev, sample_t cur, sample_t thr);
    return (prev <= thr) && (cur > thr);
  endfunction

endpackage

// File: rtl/v1_filter_ctrl_if.sv
// Event record channel: valid/ready handshake carrying the pulse amplitude and peak timestamp.
interface v1_filter_ctrl_if #(
  parameter int TS_W = 32
);
  logic                  event_valid;
  logic                  event_ready;
  v1_param::sample_t     event_amp;
  logic [TS_W-1:0]       event_time;

  modport master (
    output event_valid,
    output event_amp,
    output event_time,
    input  event_ready
  );

  modport slave (
    input  event_valid,
    input  event_amp,
    input  event_time,
    output event_ready
  );
endinterface

// File: rtl/v1_filter_ctrl_peak_hold.sv
// Holds the running maximum of a pulse and the timestamp at which it was first reached.
module v1_peak_hold
  import v1_param::*;
#(
  parameter int TS_W = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_load,      // first sample of a pulse
  input  logic            i_update,    // later samples of the same pulse
  input  sample_t         i_sample,
  input  logic [TS_W-1:0] i_time,
  output sample_t         o_peak,
  output logic [TS_W-1:0] o_peak_time
);

  sample_t         r_peak;
  logic [TS_W-1:0] r_peak_time;
  logic            w_higher;

  // Strictly greater only, so a repeated maximum keeps the earlier timestamp.
  assign w_higher = i_sample > r_peak;

  // Load on the crossing sample, then replace only on a new strict maximum.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_peak      <= '0;
      r_peak_time <= '0;
    end else if (i_load || (i_update && w_higher)) begin
      r_peak      <= i_sample;
      r_peak_time <= i_time;
    end
  end

  assign o_peak      = r_peak;
  assign o_peak_time = r_peak_time;

endmodule

// File: rtl/v1_filter_ctrl.sv
// Run controller for a pulse-shaping filter: flushes and settles the filter, detects
// threshold crossings, captures each pulse peak and hands it out as an event record.
module v1_filter_ctrl
  import v1_param::*;
#(
  parameter int TS_W   = 32,
  parameter int DROP_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  sample_t           threshold,
  input  sample_t           filter_data,
  output logic              filter_rst_n,
  output logic              busy,
  output logic [DROP_W-1:0] drop_cnt,
  v1_filter_ctrl_if.master  evt
);

  localparam logic [CNT_W-1:0] FLUSH_LAST  = CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  state_t            r_state;
  state_t            w_state_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [TS_W-1:0]   r_ts;
  sample_t           r_prev;
  logic              r_stop_lat;
  sample_t           r_amp;
  logic [TS_W-1:0]   r_time;
  logic [DROP_W-1:0] r_drop;

  logic              w_cross;
  logic              w_load;
  logic              w_update;
  logic              w_report;
  logic              w_enter_flush;
  sample_t           w_peak;
  logic [TS_W-1:0]   w_peak_time;

  assign w_cross       = rising_cross(r_prev, filter_data, threshold);
  assign w_enter_flush = (r_state == S_IDLE) && (w_state_next == S_FLUSH);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // Next state plus the one-cycle strobes that steer peak capture and record loading.
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_update     = 1'b0;
    w_report     = 1'b0;
    case (r_state)
      S_IDLE:   if (start && !stop) w_state_next = S_FLUSH;
      S_FLUSH: begin
        if (stop)                     w_state_next = S_IDLE;
        else if (r_cnt == FLUSH_LAST) w_state_next = S_SETTLE;
      end
      S_SETTLE: begin
        if (stop)                      w_state_next = S_IDLE;
        else if (r_cnt == SETTLE_LAST) w_state_next = S_ARMED;
      end
      S_ARMED: begin
        if (stop) begin
          w_state_next = S_IDLE;
        end else if (w_cross) begin
          w_state_next = S_PEAK;
          w_load       = 1'b1;
        end
      end
      S_PEAK: begin
        // A stop here abandons the pulse: no record, no drop count.
        if (stop) begin
          w_state_next = S_IDLE;
        end else if (filter_data <= threshold) begin
          w_state_next = S_REPORT;
          w_report     = 1'b1;
        end else begin
          w_update = 1'b1;
        end
      end
      S_REPORT: begin
        if (evt.event_ready) w_state_next = (r_stop_lat || stop) ? S_IDLE : S_ARMED;
      end
      default:  w_state_next = S_IDLE;
    endcase
  end

  // Phase counter for FLUSH and SETTLE; restarts on every state change.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                          r_cnt <= '0;
    else if (r_state != w_state_next)                   r_cnt <= '0;
    else if (r_state == S_FLUSH || r_state == S_SETTLE) r_cnt <= r_cnt + 1'b1;
  end

  // Timestamp: zeroed when a run starts, free-running (wrapping) once the filter is out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_ts <= '0;
    else if (w_enter_flush)
      r_ts <= '0;
    else if (r_state == S_SETTLE || r_state == S_ARMED || r_state == S_PEAK || r_state == S_REPORT)
      r_ts <= r_ts + 1'b1;
  end

  // Previous sample for crossing detection; held at zero while the filter is flushed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  r_prev <= '0;
    else if (r_state == S_FLUSH) r_prev <= '0;
    else                        r_prev <= filter_data;
  end

  // Remembers a stop seen while a record waits, so the handshake ends the run.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                                    r_stop_lat <= 1'b0;
    else if (r_state == S_REPORT && w_state_next == S_REPORT)     r_stop_lat <= r_stop_lat | stop;
    else                                                          r_stop_lat <= 1'b0;
  end

  // Event record: frozen at the end of the pulse so it stays stable through the handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_amp  <= '0;
      r_time <= '0;
    end else if (w_report) begin
      r_amp  <= w_peak;
      r_time <= w_peak_time;
    end
  end

  // Lost-pulse counter: crossings while a record is still pending, saturating.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_drop <= '0;
    else if (w_enter_flush)
      r_drop <= '0;
    else if (r_state == S_REPORT && w_cross && (r_drop != {DROP_W{1'b1}}))
      r_drop <= r_drop + 1'b1;
  end

  v1_peak_hold #(
    .TS_W (TS_W)
  ) u_peak (
    .clk         (clk),
    .reset       (reset),
    .i_load      (w_load),
    .i_update    (w_update),
    .i_sample    (filter_data),
    .i_time      (r_ts),
    .o_peak      (w_peak),
    .o_peak_time (w_peak_time)
  );

  assign filter_rst_n    = !(r_state == S_IDLE || r_state == S_FLUSH);
  assign busy            = (r_state != S_IDLE);
  assign drop_cnt        = r_drop;
  assign evt.event_valid = (r_state == S_REPORT);
  assign evt.event_amp   = r_amp;
  assign evt.event_time  = r_time;

endmodule

// File: tb/tb_v1_filter_ctrl.sv
// Scoreboard bench for v1_filter_ctrl: expected records are queued as pulses are driven
// and popped when the DUT completes a handshake.
module tb_v1_filter_ctrl;
  import v1_param::*;

  localparam int TS_W   = 32;
  localparam int DROP_W = 2;   // narrow so saturation is reachable in a few pulses

  typedef struct {
    logic signed [SIZE_FILTER_DATA-1:0] amp;
    logic [TS_W-1:0]                    tm;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              stop = 1'b0;
  sample_t           threshold;
  sample_t           filter_data;
  logic              filter_rst_n;
  logic              busy;
  logic [DROP_W-1:0] drop_cnt;

  v1_filter_ctrl_if #(.TS_W(TS_W)) ev ();

  v1_filter_ctrl #(
    .TS_W   (TS_W),
    .DROP_W (DROP_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .stop         (stop),
    .threshold    (threshold),
    .filter_data  (filter_data),
    .filter_rst_n (filter_rst_n),
    .busy         (busy),
    .drop_cnt     (drop_cnt),
    .evt          (ev)
  );

  always #5 clk = ~clk;

  int n_pos = 0;
  always @(posedge clk) n_pos <= n_pos + 1;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   hs_cnt = 0;
  int   cur_n = 0;
  int   c0 = 0;
  exp_t sb_q[$];
  exp_t e;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  // Timestamp the DUT holds during the current cycle of the current run.
  function automatic logic [TS_W-1:0] tnow();
    return TS_W'(cur_n - c0 - 4);
  endfunction

  // One cycle of stimulus, applied on the falling edge; a valid&ready seen here
  // completes at the next rising edge, so the record is checked now.
  task automatic drive_cycle(input int d, input logic rdy, input logic st, input logic sp);
    @(negedge clk);
    filter_data    = sample_t'(d);
    ev.event_ready = rdy;
    start          = st;
    stop           = sp;
    cur_n          = n_pos;
    if (ev.event_valid && ev.event_ready) begin
      hs_cnt++;
      if (sb_q.size() == 0) begin
        chk("unexpected_event", 1, 0);
      end else begin
        e = sb_q.pop_front();
        chk("ev_amp", 64'(ev.event_amp), 64'(e.amp));
        chk("ev_time", 64'(ev.event_time), 64'(e.tm));
        $display("event amp=%0d time=%0d", ev.event_amp, ev.event_time);
      end
    end
  endtask

  function automatic int pulse_a(int k);
    case (k)
      14: return 150;   // lands in SETTLE, must be ignored
      15: return 50;
      16: return 150;   // first ARMED cycle: crossing
      17: return 300;
      18: return 300;
      19: return 200;
      20: return 90;
      default: return 0;
    endcase
  endfunction

  initial begin
    threshold      = sample_t'(100);
    filter_data    = '0;
    ev.event_ready = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_filter_rst_n", 64'(filter_rst_n), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_valid", 64'(ev.event_valid), 0);
    chk("rst_amp", 64'(ev.event_amp), 0);
    chk("rst_time", 64'(ev.event_time), 0);
    chk("rst_drop", 64'(drop_cnt), 0);
    reset = 1'b0;

    // start and stop together in IDLE stays idle
    drive_cycle(0, 1'b1, 1'b1, 1'b1);
    drive_cycle(0, 1'b1, 1'b0, 1'b0);
    chk("start_stop_idle", 64'(busy), 0);

    // Run 1: flush length, settle length, first pulse
    drive_cycle(0, 1'b1, 1'b1, 1'b0);
    c0 = cur_n + 1;
    for (int k = 0; k <= 20; k++) begin
      drive_cycle(pulse_a(k), 1'b1, 1'b0, 1'b0);
      if (k <= 4) chk("flush_rstn", 64'(filter_rst_n), (k < 4) ? 0 : 1);
      if (k == 0) chk("run_busy", 64'(busy), 1);
      if (k == 17) sb_q.push_back('{amp: sample_t'(300), tm: tnow()});
      if (k == 20) chk("valid_before", 64'(ev.event_valid), 0);
    end
    drive_cycle(50, 1'b1, 1'b0, 1'b0);
    chk("valid_after", 64'(ev.event_valid), 1);

    // Pulse held in REPORT while a second pulse crosses
    drive_cycle(50, 1'b0, 1'b0, 1'b0);
    chk("armed_valid0", 64'(ev.event_valid), 0);
    drive_cycle(250, 1'b0, 1'b0, 1'b0);
    sb_q.push_back('{amp: sample_t'(250), tm: tnow()});
    drive_cycle(120, 1'b0, 1'b0, 1'b0);
    drive_cycle(60, 1'b0, 1'b0, 1'b0);
    drive_cycle(50, 1'b0, 1'b0, 1'b0);
    chk("report_valid", 64'(ev.event_valid), 1);
    drive_cycle(200, 1'b0, 1'b0, 1'b0);
    drive_cycle(50, 1'b0, 1'b0, 1'b0);
    chk("drop_one", 64'(drop_cnt), 1);
    chk("rec_hold_amp", 64'(ev.event_amp), 64'(sample_t'(250)));
    drive_cycle(50, 1'b1, 1'b0, 1'b0);
    drive_cycle(150, 1'b1, 1'b0, 1'b0);
    chk("back_armed", 64'(ev.event_valid), 0);
    sb_q.push_back('{amp: sample_t'(150), tm: tnow()});
    drive_cycle(50, 1'b1, 1'b0, 1'b0);
    drive_cycle(50, 1'b1, 1'b0, 1'b0);

    // stop during PEAK discards the pulse
    drive_cycle(150, 1'b1, 1'b0, 1'b0);
    drive_cycle(200, 1'b1, 1'b0, 1'b1);
    drive_cycle(50, 1'b1, 1'b0, 1'b0);
    chk("stop_peak_busy", 64'(busy), 0);
    chk("stop_peak_valid", 64'(ev.event_valid), 0);
    drive_cycle(150, 1'b1, 1'b0, 1'b0);
    drive_cycle(50, 1'b1, 1'b0, 1'b0);
    chk("stop_peak_novalid", 64'(ev.event_valid), 0);
    chk("stop_peak_drop", 64'(drop_cnt), 1);

    // Run 2: drop counter clears, stop in REPORT waits for the handshake
    drive_cycle(0, 1'b1, 1'b1, 1'b0);
    c0 = cur_n + 1;
    drive_cycle(0, 1'b1, 1'b0, 1'b0);
    chk("drop_clear", 64'(drop_cnt), 0);
    for (int k = 1; k <= 15; k++) drive_cycle(0, 1'b1, 1'b0, 1'b0);
    drive_cycle(150, 1'b1, 1'b0, 1'b0);
    sb_q.push_back('{amp: sample_t'(150), tm: tnow()});
    drive_cycle(50, 1'b1, 1'b0, 1'b0);
    drive_cycle(50, 1'b0, 1'b0, 1'b1);
    chk("stop_rep_valid", 64'(ev.event_valid), 1);
    drive_cycle(50, 1'b1, 1'b0, 1'b0);
    chk("stop_rep_busy", 64'(busy), 1);
    drive_cycle(50, 1'b1, 1'b0, 1'b0);
    chk("stop_rep_idle", 64'(busy), 0);

    // Run 3: drop saturation, then asynchronous reset with a record pending
    drive_cycle(0, 1'b1, 1'b1, 1'b0);
    c0 = cur_n + 1;
    for (int k = 0; k <= 15; k++) drive_cycle(0, 1'b1, 1'b0, 1'b0);
    drive_cycle(150, 1'b0, 1'b0, 1'b0);
    sb_q.push_back('{amp: sample_t'(150), tm: tnow()});
    drive_cycle(50, 1'b0, 1'b0, 1'b0);
    drive_cycle(50, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      drive_cycle(200, 1'b0, 1'b0, 1'b0);
      drive_cycle(50, 1'b0, 1'b0, 1'b0);
    end
    chk("drop_sat", 64'(drop_cnt), 3);
    chk("sat_valid", 64'(ev.event_valid), 1);
    #2 reset = 1'b1;
    #1;
    chk("arst_filter_rst_n", 64'(filter_rst_n), 0);
    chk("arst_busy", 64'(busy), 0);
    chk("arst_valid", 64'(ev.event_valid), 0);
    chk("arst_amp", 64'(ev.event_amp), 0);
    chk("arst_time", 64'(ev.event_time), 0);
    chk("arst_drop", 64'(drop_cnt), 0);
    chk("sb_pending", 64'(sb_q.size()), 1);
    if (sb_q.size() != 0) void'(sb_q.pop_front());
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) drive_cycle(50, 1'b1, 1'b0, 1'b0);
    chk("post_rst_valid", 64'(ev.event_valid), 0);
    chk("post_rst_busy", 64'(busy), 0);
    chk("sb_empty", 64'(sb_q.size()), 0);
    chk("event_count", 64'(hs_cnt), 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
